// File: rtl/aes_spi_ctrl.sv
// aes_spi_ctrl: SPI-style host front end for an AES core.
//   The host shifts in 256 bits ({plaintext, key}, MSB first) while ce is high.
//   A complete frame commits the block and pulses load to the core. The block
//   then waits for done, with a timeout. It captures the cyphertext and the
//   host reads it back on sdo, one bit per sck fall, during a second ce frame.
// Ports:
//   clk, nreset            system clock, asynchronous active-low reset
//   sck, sdi, ce           host SPI inputs (asynchronous to clk, synchronized here)
//   sdo                    serial readout, valid in READY/SHIFT_OUT, 0 otherwise
//   rdy                    cyphertext available for readout
//   err                    sticky WAIT timeout flag, cleared on next START
//   load                   one-cycle start pulse to the AES core
//   plaintext, key         committed block to encrypt
//   done, cyphertext       AES core completion level and result
module aes_spi_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_MAX    = 1023
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         sck,
  input  logic         sdi,
  input  logic         ce,
  output logic         sdo,
  output logic         rdy,
  output logic         err,
  output logic         load,
  output logic [127:0] plaintext,
  output logic [127:0] key,
  input  logic         done,
  input  logic [127:0] cyphertext
);

  localparam int         WCW       = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [1:0] FILL_N    = 2'(SYNC_STAGES);
  localparam logic [8:0] FULL_CNT  = 9'd256;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_IN, S_START, S_WAIT, S_READY, S_SHIFT_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ce_prev_q, ce_prev_d;
  logic [1:0]             fill_cnt_q, fill_cnt_d;
  logic                   ce_ok_q, ce_ok_d;
  logic [8:0]             bit_cnt_q, bit_cnt_d;
  logic [255:0]           shift_in_q, shift_in_d;
  logic [127:0]           pt_q, pt_d;
  logic [127:0]           key_q, key_d;
  logic [127:0]           out_q, out_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                   err_q, err_d;

  logic sck_s, sdi_s, ce_s;
  logic sck_rise, sck_fall, ce_rise, ce_fall;

  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    ce_sync_d  = {ce_sync_q[SYNC_STAGES-2:0], ce};
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    sdi_s      = sdi_sync_q[SYNC_STAGES-1];
    ce_s       = ce_sync_q[SYNC_STAGES-1];
    sck_prev_d = sck_s;
    ce_prev_d  = ce_s;
    // The synchronizer comes out of reset holding zeros. Only once it has
    // filled with real samples can a low ce be trusted. Until ce is seen low,
    // a ce already high at reset release is not treated as a rise.
    fill_cnt_d = (fill_cnt_q == FILL_N) ? fill_cnt_q : fill_cnt_q + 2'd1;
    ce_ok_d    = ce_ok_q | ((fill_cnt_q == FILL_N) & ~ce_s);
    sck_rise   = sck_s & ~sck_prev_q;
    sck_fall   = ~sck_s & sck_prev_q;
    ce_rise    = ce_s & ~ce_prev_q & ce_ok_q;
    ce_fall    = ~ce_s & ce_prev_q;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_in_d = shift_in_q;
    pt_d       = pt_q;
    key_d      = key_q;
    out_d      = out_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (ce_rise) begin
          state_d   = S_SHIFT_IN;
          bit_cnt_d = 9'd0;
        end
      end
      S_SHIFT_IN: begin
        if (ce_fall) begin
          state_d = (bit_cnt_q == FULL_CNT) ? S_START : S_IDLE;
        end else if (sck_rise && bit_cnt_q != FULL_CNT) begin
          shift_in_d = {shift_in_q[254:0], sdi_s};
          bit_cnt_d  = bit_cnt_q + 9'd1;
        end
      end
      S_START: begin
        pt_d       = shift_in_q[255:128];
        key_d      = shift_in_q[127:0];
        err_d      = 1'b0;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          out_d   = cyphertext;
          state_d = S_READY;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_READY: begin
        if (ce_rise) state_d = S_SHIFT_OUT;
      end
      S_SHIFT_OUT: begin
        if (ce_fall) begin
          state_d = S_IDLE;
        end else if (sck_fall) begin
          // Zeros shift in behind the data, so sdo reads 0 after 128 falls.
          out_d = {out_q[126:0], 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      ce_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      ce_prev_q  <= 1'b0;
      fill_cnt_q <= 2'd0;
      ce_ok_q    <= 1'b0;
      bit_cnt_q  <= 9'd0;
      shift_in_q <= '0;
      pt_q       <= '0;
      key_q      <= '0;
      out_q      <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      ce_sync_q  <= ce_sync_d;
      sck_prev_q <= sck_prev_d;
      ce_prev_q  <= ce_prev_d;
      fill_cnt_q <= fill_cnt_d;
      ce_ok_q    <= ce_ok_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_in_q <= shift_in_d;
      pt_q       <= pt_d;
      key_q      <= key_d;
      out_q      <= out_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign load      = (state_q == S_START);
  assign rdy       = (state_q == S_READY) || (state_q == S_SHIFT_OUT);
  assign sdo       = rdy ? out_q[127] : 1'b0;
  assign err       = err_q;
  assign plaintext = pt_q;
  assign key       = key_q;

endmodule

// File: tb/tb_aes_spi_ctrl.sv
// tb_aes_spi_ctrl: directed bench for aes_spi_ctrl. It drives host SPI frames,
// plays the part of a stub AES core, and checks against hand-computed vectors.
module tb_aes_spi_ctrl;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         sck = 1'b0;
  logic         sdi = 1'b0;
  logic         ce = 1'b0;
  logic         sdo, rdy, err, load;
  logic [127:0] plaintext, key;
  logic         done = 1'b0;
  logic [127:0] cyphertext = '0;

  logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;

  aes_spi_ctrl #(.SYNC_STAGES(2), .WAIT_MAX(1023)) dut (
    .clk(clk), .nreset(nreset), .sck(sck), .sdi(sdi), .ce(ce),
    .sdo(sdo), .rdy(rdy), .err(err), .load(load),
    .plaintext(plaintext), .key(key), .done(done), .cyphertext(cyphertext)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (load === 1'b1) load_cnt <= load_cnt + 1;

  // Raise ce, clock nbits bits MSB first (bits past 256 are ones), optionally drop ce.
  task automatic send_frame(input logic [255:0] data, input int nbits, input bit drop_ce);
    ce = 1'b1;
    repeat (8) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 256) ? data[255-i] : 1'b1;
      repeat (5) @(posedge clk);
      sck = 1'b1;
      repeat (5) @(posedge clk);
      sck = 1'b0;
    end
    repeat (5) @(posedge clk);
    if (drop_ce) ce = 1'b0;
  endtask

  task automatic wait_load(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (load === 1'b1) seen = 1'b1;
    end
  endtask

  // Full readout frame: value MSB first, then sdo after the 128th fall.
  task automatic read_block(output logic [127:0] val, output logic tail);
    ce = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    val[127] = sdo;
    for (int i = 1; i <= 128; i++) begin
      sck = 1'b1;
      repeat (5) @(posedge clk);
      sck = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      if (i < 128) val[127-i] = sdo;
      else tail = sdo;
    end
    ce = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({sdo, rdy, err, load} !== 4'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got sdo/rdy/err/load=%b expected 0000", tag, {sdo, rdy, err, load});
    end
    checks++;
    if (plaintext !== 128'h0) begin
      errors++;
      $display("FAIL %s_plaintext: got %h expected 0", tag, plaintext);
    end
    checks++;
    if (key !== 128'h0) begin
      errors++;
      $display("FAIL %s_key: got %h expected 0", tag, key);
    end
  endtask

  task automatic check_commit(input string tag, input int l0, input logic [127:0] ept,
                              input logic [127:0] ekey);
    bit seen;
    wait_load(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_load_seen: got no load expected load pulse", tag);
    end
    @(negedge clk);
    checks++;
    if (plaintext !== ept) begin
      errors++;
      $display("FAIL %s_plaintext: got %h expected %h", tag, plaintext, ept);
    end
    checks++;
    if (key !== ekey) begin
      errors++;
      $display("FAIL %s_key: got %h expected %h", tag, key, ekey);
    end
    checks++;
    if (load_cnt - l0 !== 1) begin
      errors++;
      $display("FAIL %s_load_count: got %0d expected 1", tag, load_cnt - l0);
    end
  endtask

  // Stub core answers, then the host reads the cyphertext back.
  task automatic core_reply_and_read(input string tag, input int delay);
    logic [127:0] val;
    logic         tail;
    repeat (delay) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s_rdy_before_done: got %b expected 0", tag, rdy);
    end
    done = 1'b1;
    cyphertext = CT1;
    @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_rdy_after_done: got %b expected 1", tag, rdy);
    end
    done = 1'b0;
    cyphertext = '0;
    read_block(val, tail);
    checks++;
    if (val !== CT1) begin
      errors++;
      $display("FAIL %s_readout: got %h expected %h", tag, val, CT1);
    end
    checks++;
    if (tail !== 1'b0) begin
      errors++;
      $display("FAIL %s_sdo_after_128: got %b expected 0", tag, tail);
    end
    checks++;
    if ({rdy, sdo} !== 2'b00) begin
      errors++;
      $display("FAIL %s_rdy_sdo_after_ce_fall: got %b expected 00", tag, {rdy, sdo});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    nreset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_zero_outputs("reset_released");
  endtask

  task automatic test_full_transfer();
    int l0 = load_cnt;
    send_frame({PT1, KEY1}, 256, 1'b1);
    check_commit("v1", l0, PT1, KEY1);
  endtask

  task automatic test_readout();
    core_reply_and_read("v2", 20);
  endtask

  task automatic test_done_ignored_idle();
    done = 1'b1;
    cyphertext = CT1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL idle_done_ignored: got rdy=%b expected 0", rdy);
    end
    done = 1'b0;
    cyphertext = '0;
  endtask

  task automatic test_short_frame();
    int l0 = load_cnt;
    send_frame({KEY1, PT1}, 200, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (load_cnt !== l0) begin
      errors++;
      $display("FAIL v3_no_load: got %0d loads expected 0", load_cnt - l0);
    end
    checks++;
    if (plaintext !== PT1 || key !== KEY1) begin
      errors++;
      $display("FAIL v3_hold: got pt=%h key=%h expected pt=%h key=%h", plaintext, key, PT1, KEY1);
    end
  endtask

  // 300-bit frame commits the first 256 bits; the core never answers -> timeout.
  task automatic test_overlong_and_timeout();
    int l0 = load_cnt;
    send_frame({KEY1, PT1}, 300, 1'b1);
    check_commit("v4", l0, KEY1, PT1);
    repeat (1000) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL v5_err_early: got %b expected 0", err);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL v5_timeout: got err=%b rdy=%b expected err=1 rdy=0", err, rdy);
    end
    l0 = load_cnt;
    send_frame({PT1, KEY1}, 256, 1'b1);
    check_commit("v5_recover", l0, PT1, KEY1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL v5_err_cleared: got %b expected 0", err);
    end
    core_reply_and_read("v5_recover", 5);
  endtask

  task automatic test_reset_mid_transfer();
    int l0;
    bit seen;
    send_frame({PT1, KEY1}, 100, 1'b0);
    #3 nreset = 1'b0;
    #1;
    check_zero_outputs("v6_shift_reset");
    #20 nreset = 1'b1;
    l0 = load_cnt;
    // ce stayed high through reset: remaining bits must not start a transfer.
    send_frame({PT1, KEY1}, 156, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (load_cnt !== l0 || key !== 128'h0) begin
      errors++;
      $display("FAIL v6_no_restart: got loads=%0d key=%h expected 0 loads key 0", load_cnt - l0, key);
    end
    send_frame({PT1, KEY1}, 256, 1'b1);
    wait_load(seen);
    repeat (10) @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    check_zero_outputs("v6_wait_reset");
    #20 nreset = 1'b1;
    repeat (1100) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL v6_no_timeout_after_reset: got %b expected 0", err);
    end
    l0 = load_cnt;
    send_frame({PT1, KEY1}, 256, 1'b1);
    check_commit("v6_final", l0, PT1, KEY1);
    core_reply_and_read("v6_final", 20);
  endtask

  initial begin
    test_reset();
    test_full_transfer();
    test_readout();
    test_done_ignored_idle();
    test_short_frame();
    test_overlong_and_timeout();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
